store_issue_gate: RTL

Store-ordering gate between the store unit's commit path and the write-through data cache / AXI write path. It admits store requests downstream, counts outstanding (issued, not yet acknowledged) stores up to a fixed limit, and serialises stores to non-idempotent regions so that each one issues alone. It also drains all outstanding stores on a fence request.

---
 rtl/store_gate_pkg.sv | 23 ++
 rtl/ni_region_match.sv | 27 ++
 rtl/store_issue_gate.sv | 125 ++++++++++++
 3 files changed

// File: rtl/store_gate_pkg.sv
// Shared types for the store issue gate and its address classifier.
// Region hits are computed at 65 bits so base+length never wraps.
package store_gate_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ORDERED = 2'd1,
    DRAIN   = 2'd2
  } gate_state_e;

  localparam int unsigned RuleWidth = 64;

  function automatic logic in_region(
    input logic [64:0] addr,
    input logic [64:0] base,
    input logic [63:0] len
  );
    logic [64:0] lim;
    lim = base + {1'b0, len};
    return (len != '0) && (addr >= base) && (addr < lim);
  endfunction

endpackage

// File: rtl/ni_region_match.sv
// Combinational non-idempotent region classifier; shared with the load path.
// A rule with zero length is disabled.
module ni_region_match
  import store_gate_pkg::*;
#(
  parameter int unsigned AddrWidth = 34,
  parameter int unsigned NrNiRules = 2,
  parameter logic [NrNiRules-1:0][RuleWidth-1:0] NiBase   = '0,
  parameter logic [NrNiRules-1:0][RuleWidth-1:0] NiLength = '0
) (
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 is_ni_o
);

  logic [NrNiRules-1:0] hit;

  for (genvar i = 0; i < NrNiRules; i++) begin : g_rule
    logic [64:0] base;
    logic [64:0] addr;
    assign base = 65'(NiBase[i][AddrWidth-1:0]);
    assign addr = 65'(addr_i);
    assign hit[i] = in_region(addr, base, NiLength[i]);
  end

  assign is_ni_o = |hit;

endmodule

// File: rtl/store_issue_gate.sv
// Store ordering gate: caps in-flight stores, serialises NI stores, drains on fence.
// Define CVA6_STORE_GATE_PERF_EN to add the stall_cycles_o counter.
module store_issue_gate
  import store_gate_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned CntWidth  = $clog2(MaxOutstanding + 1),
  parameter int unsigned AddrWidth = 34,
  parameter int unsigned NrNiRules = 2,
  parameter logic [NrNiRules-1:0][RuleWidth-1:0] NiBase   = '0,
  parameter logic [NrNiRules-1:0][RuleWidth-1:0] NiLength = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  input  logic                 ack_i,
  input  logic                 fence_i,
  output logic                 fence_done_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 ack_err_o
`ifdef CVA6_STORE_GATE_PERF_EN
  ,
  output logic [31:0]          stall_cycles_o
`endif
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  gate_state_e state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic is_ni, allow, hs, inc, dec;

  ni_region_match #(
    .AddrWidth (AddrWidth),
    .NrNiRules (NrNiRules),
    .NiBase    (NiBase),
    .NiLength  (NiLength)
  ) u_ni (
    .addr_i  (req_addr_i),
    .is_ni_o (is_ni)
  );

  assign allow = (cnt_q < CntMax) && (state_q == RUN)
              && (!is_ni || (cnt_q == '0));

  assign mem_valid_o = req_valid_i && allow;
  assign req_ready_o = mem_ready_i && allow;
  assign hs = mem_valid_o && mem_ready_i;

  // An ack with nothing in flight is an error and never underflows.
  assign inc = hs;
  assign dec = ack_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc && !dec) cnt_d = cnt_q + CntOne;
    else if (dec && !inc) cnt_d = cnt_q - CntOne;
    if (ack_i && (cnt_q == '0)) err_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (fence_i) state_d = DRAIN;
        else if (hs && is_ni) state_d = ORDERED;
      end
      ORDERED: begin
        if (fence_i) state_d = DRAIN;
        else if (cnt_d == '0) state_d = RUN;
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign fence_done_o  = done_q;
  assign ack_err_o     = err_q;

`ifdef CVA6_STORE_GATE_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (req_valid_i && !allow && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule
